// File: rtl/proc_sequencer.sv
// Instruction sequencer for proc: fetches words from synchronous program memory, issues them
// with Run, supplies the mvi immediate, and handles start/step/halt plus a Done watchdog.
module proc_sequencer #(
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  input  logic          Step,
  input  logic          HaltReq,
  output logic [AW-1:0] MemAddr,
  output logic          MemRd,
  input  logic [15:0]   MemData,
  output logic [15:0]   DIN,
  output logic          Run,
  input  logic          Done,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Fault,
  output logic [15:0]   Retired
);

  localparam int unsigned WdW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0]  OpMvi    = 3'b100;
  localparam logic [15:0] HaltWord = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StExec,
    StHalted,
    StFault
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [15:0]    din_q, din_d;
  logic [15:0]    retired_q, retired_d;
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           mvi_q, mvi_d;
  logic           run_q, busy_q, halted_q, fault_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    din_d     = din_q;
    retired_d = retired_q;
    wdog_d    = wdog_q;
    mvi_d     = mvi_q;
    MemRd     = 1'b0;
    MemAddr   = '0;
    unique case (state_q)
      StIdle, StHalted, StFault: begin
        if (Start) begin
          pc_d    = StartAddr;
          state_d = StFetch;
        end
      end
      StFetch: begin
        MemRd   = 1'b1;
        MemAddr = pc_q;
        state_d = StLoad;
      end
      StLoad: begin
        if (MemData == HaltWord) begin
          state_d = StHalted;
        end else begin
          din_d   = MemData;
          mvi_d   = (MemData[14:12] == OpMvi);
          wdog_d  = '0;
          state_d = StExec;
          // Prefetch the immediate so it arrives during the first EXEC cycle.
          if (MemData[14:12] == OpMvi) begin
            MemRd   = 1'b1;
            MemAddr = pc_q + AW'(1);
          end
        end
      end
      StExec: begin
        // A zero watchdog marks the first EXEC cycle, when the immediate is on MemData.
        if (mvi_q && (wdog_q == '0)) begin
          din_d = MemData;
        end
        if (Done) begin
          pc_d      = pc_q + (mvi_q ? AW'(2) : AW'(1));
          retired_d = retired_q + 16'd1;
          wdog_d    = '0;
          state_d   = (HaltReq || Step) ? StHalted : StFetch;
        end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
          wdog_d  = '0;
          state_d = StFault;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      din_q     <= '0;
      retired_q <= '0;
      wdog_q    <= '0;
      mvi_q     <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      din_q     <= din_d;
      retired_q <= retired_d;
      wdog_q    <= wdog_d;
      mvi_q     <= mvi_d;
      run_q     <= (state_d == StExec);
      busy_q    <= (state_d == StFetch) || (state_d == StLoad) || (state_d == StExec);
      halted_q  <= (state_d == StHalted);
      fault_q   <= (state_d == StFault);
    end
  end

  assign DIN     = din_q;
  assign PC      = pc_q;
  assign Run     = run_q;
  assign Busy    = busy_q;
  assign Halted  = halted_q;
  assign Fault   = fault_q;
  assign Retired = retired_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: directed programs plus random programs checked
// against a per-instruction transaction model.
module tb_proc_sequencer;

  localparam int unsigned AW      = 8;
  localparam int unsigned TIMEOUT = 15;

  logic          Clock = 1'b0;
  logic          Reset, Start, Step, HaltReq, Done;
  logic [AW-1:0] StartAddr;
  logic [AW-1:0] MemAddr, PC;
  logic          MemRd, Run, Busy, Halted, Fault;
  logic [15:0]   MemData, DIN, Retired;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;

  // Program description consumed by run_prog.
  logic [7:0]  p_start;
  int          p_n;
  logic [15:0] p_word  [16];
  logic [15:0] p_imm   [16];
  bit          p_mvi   [16];
  int          p_delay [16];
  bit          p_hr    [16];
  bit          p_junk  [16];

  proc_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .StartAddr(StartAddr),
    .Step     (Step),
    .HaltReq  (HaltReq),
    .MemAddr  (MemAddr),
    .MemRd    (MemRd),
    .MemData  (MemData),
    .DIN      (DIN),
    .Run      (Run),
    .Done     (Done),
    .PC       (PC),
    .Busy     (Busy),
    .Halted   (Halted),
    .Fault    (Fault),
    .Retired  (Retired)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (MemRd) MemData <= mem[MemAddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] addr);
    Start     = 1'b1;
    StartAddr = addr;
    tick();
    Start     = 1'b0;
    StartAddr = 8'($urandom);
  endtask

  task automatic load_prog();
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    a = p_start;
    for (int i = 0; i < p_n; i++) begin
      mem[a] = p_word[i];
      a = a + 8'd1;
      if (p_mvi[i]) begin
        mem[a] = p_imm[i];
        a = a + 8'd1;
      end
    end
    mem[a] = 16'hFFFF;
  endtask

  // Executes the loaded program from p_start, acting as proc and checking each instruction.
  task automatic run_prog(input bit step_mode);
    logic [7:0] pc_exp;
    logic [7:0] nxt;
    pc_exp = p_start;
    Step   = step_mode;
    pulse_start(pc_exp);
    for (int i = 0; i < p_n; i++) begin
      check("fetch_flags", {Busy, Run, MemRd}, 3'b101);
      check("fetch_addr", MemAddr, pc_exp);
      check("fetch_pc", PC, pc_exp);
      tick();
      check("load_rd", MemRd, p_mvi[i]);
      nxt = pc_exp + 8'd1;
      if (p_mvi[i]) check("load_addr", MemAddr, nxt);
      tick();
      for (int k = 1; k <= p_delay[i]; k++) begin
        check("exec_flags", {Run, Busy}, 2'b11);
        if (k == 1) check("exec_din", DIN, p_word[i]);
        else if (p_mvi[i]) check("exec_imm", DIN, p_imm[i]);
        check("exec_pc", PC, pc_exp);
        Done      = (k == p_delay[i]);
        HaltReq   = p_hr[i];
        Start     = p_junk[i];
        StartAddr = 8'($urandom);
        tick();
      end
      Done    = 1'b0;
      Start   = 1'b0;
      HaltReq = 1'b0;
      pc_exp  = pc_exp + (p_mvi[i] ? 8'd2 : 8'd1);
      exp_retired++;
      check("retired", Retired, exp_retired[15:0]);
      if (step_mode || p_hr[i]) begin
        check("stop_flags", {Halted, Busy, Run}, 3'b100);
        check("stop_pc", PC, pc_exp);
        HaltReq = 1'($urandom);
        pulse_start(pc_exp);
      end
    end
    check("sent_fetch", MemAddr, pc_exp);
    tick();
    tick();
    HaltReq = 1'b0;
    check("end_flags", {Halted, Busy, Run, Fault}, 4'b1000);
    check("end_pc", PC, pc_exp);
    check("end_retired", Retired, exp_retired[15:0]);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      p_mvi[i]   = 1'b0;
      p_imm[i]   = 16'h0;
      p_hr[i]    = 1'b0;
      p_junk[i]  = 1'b0;
      p_delay[i] = 2;
    end
  endtask

  initial begin
    int runs;
    Reset = 1'b1; Start = 1'b0; Step = 1'b0; HaltReq = 1'b0; Done = 1'b0; StartAddr = '0;
    #12;
    check("rst_flags", {Run, Busy, Halted, Fault, MemRd}, 5'b0);
    check("rst_pc", PC, 0);
    check("rst_din", DIN, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_retired", Retired, 0);
    Reset = 1'b0;
    tick();

    // Straight-line program.
    clear_prog();
    p_start = 8'd0; p_n = 2;
    p_word[0] = 16'h3200; p_word[1] = 16'h3440;
    load_prog();
    run_prog(1'b0);

    // mvi with immediate.
    clear_prog();
    p_start = 8'd5; p_n = 1;
    p_word[0] = 16'h4000; p_mvi[0] = 1'b1; p_imm[0] = 16'h00AB;
    load_prog();
    run_prog(1'b0);

    // mvi at the top of memory wraps to address 0.
    clear_prog();
    p_start = 8'd255; p_n = 1;
    p_word[0] = 16'h4E00; p_mvi[0] = 1'b1; p_imm[0] = 16'h1234; p_delay[0] = 1;
    load_prog();
    run_prog(1'b0);

    // Watchdog: Done never arrives.
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h40] = 16'h1234;
    Step = 1'b0;
    pulse_start(8'h40);
    tick();
    tick();
    runs = 0;
    for (int c = 0; c < 40 && Run; c++) begin
      runs++;
      tick();
    end
    check("wd_runs", runs, TIMEOUT);
    check("wd_flags", {Fault, Run, Busy, Halted}, 4'b1000);
    check("wd_pc", PC, 8'h40);
    check("wd_retired", Retired, exp_retired[15:0]);
    pulse_start(8'h40);
    check("wd_clear", {Fault, Busy}, 2'b01);
    tick();
    tick();
    check("pre_rst_run", Run, 1'b1);

    // Asynchronous reset mid-EXEC.
    #3;
    Reset = 1'b1;
    #1;
    check("arst_flags", {Run, Busy, Fault, Halted}, 4'b0);
    check("arst_pc", PC, 0);
    check("arst_retired", Retired, 0);
    exp_retired = 0;
    Reset = 1'b0;
    tick();
    tick();
    check("arst_idle", {Busy, Halted, Run}, 3'b000);

    // Random programs.
    for (int t = 0; t < 30; t++) begin
      clear_prog();
      p_start = 8'($urandom);
      p_n = $urandom_range(1, 6);
      for (int i = 0; i < p_n; i++) begin
        p_word[i]  = 16'($urandom);
        p_mvi[i]   = ($urandom_range(0, 2) == 0);
        if (p_mvi[i]) p_word[i][14:12] = 3'b100;
        else if (p_word[i][14:12] == 3'b100) p_word[i][14:12] = 3'b011;
        if (p_word[i] == 16'hFFFF) p_word[i] = 16'h7FFF;
        p_imm[i]   = 16'($urandom);
        p_delay[i] = $urandom_range(1, 4);
        p_hr[i]    = ($urandom_range(0, 4) == 0);
        p_junk[i]  = ($urandom_range(0, 3) == 0);
      end
      load_prog();
      run_prog($urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
